// File: rtl/usb_pkt_framer_pkg.sv
// usb_pkt_framer_pkg: shared USB sniffer constants (state encodings, sync byte, INFO field layout)
package usb_pkt_framer_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // INFO word layout: [15:10] RxCMD, [9:0] data byte count
    localparam int INFO_CMD_LSB = 10;
    localparam int INFO_CNT_W   = 10;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_INFO_RD  = 4'd1;
    localparam logic [3:0] S_INFO_LAT = 4'd2;
    localparam logic [3:0] S_SYNC     = 4'd3;
    localparam logic [3:0] S_HDR_H    = 4'd4;
    localparam logic [3:0] S_HDR_L    = 4'd5;
    localparam logic [3:0] S_DATA_RD  = 4'd6;
    localparam logic [3:0] S_DATA_LAT = 4'd7;
    localparam logic [3:0] S_DATA_TX  = 4'd8;
    localparam logic [3:0] S_CHK      = 4'd9;

endpackage

// File: rtl/usb_pkt_framer_if.sv
// usb_pkt_framer_if: INFO/DATA FIFO read ports and transmitter handshake of the framer
interface usb_pkt_framer_if;

    logic        INFO_empty;
    logic        INFO_re;
    logic [15:0] INFO_DATA;
    logic        DATA_empty;
    logic        DATA_re;
    logic [7:0]  DATA_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  INFO_empty, INFO_DATA, DATA_empty, DATA_in, tx_ready,
        output INFO_re, DATA_re, tx_data, tx_valid
    );

    modport slave (
        output INFO_empty, INFO_DATA, DATA_empty, DATA_in, tx_ready,
        input  INFO_re, DATA_re, tx_data, tx_valid
    );

endinterface

// File: rtl/usb_pkt_framer.sv
// usb_pkt_framer: frames INFO + DATA FIFO contents as SYNC, INFO hi/lo, payload, XOR checksum
module usb_pkt_framer
    import usb_pkt_framer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
    parameter int         CNT_W     = INFO_CNT_W
) (
    input  logic                    clk_ULPI,
    input  logic                    rst,
    input  logic                    enable,
    usb_pkt_framer_if.master        bus,
    output logic                    busy,
    output logic [15:0]             frame_cnt
);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [15:0]      r_info;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_chk;
    logic [7:0]       r_data;
    logic [15:0]      r_frame_cnt;
    logic             w_adv;

    assign w_adv        = bus.tx_valid & bus.tx_ready;
    assign bus.INFO_re  = (r_state == S_INFO_RD) & ~bus.INFO_empty;
    assign bus.DATA_re  = (r_state == S_DATA_RD) & ~bus.DATA_empty;
    assign bus.tx_valid = r_state inside {S_SYNC, S_HDR_H, S_HDR_L, S_DATA_TX, S_CHK};
    assign busy         = r_state != S_IDLE;
    assign frame_cnt    = r_frame_cnt;

    // Every transmit state shows a register that only changes outside it, so tx_data holds while stalled
    assign bus.tx_data = (r_state == S_SYNC)    ? SYNC_BYTE     :
                         (r_state == S_HDR_H)   ? r_info[15:8]  :
                         (r_state == S_HDR_L)   ? r_info[7:0]   :
                         (r_state == S_DATA_TX) ? r_data        :
                         (r_state == S_CHK)     ? r_chk         : 8'h00;

    // Next-state: read states wait on their empty flag, transmit states wait on the handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (enable && !bus.INFO_empty) w_next = S_INFO_RD;
            S_INFO_RD:  if (!bus.INFO_empty) w_next = S_INFO_LAT;
            S_INFO_LAT: w_next = S_SYNC;
            S_SYNC:     if (w_adv) w_next = S_HDR_H;
            S_HDR_H:    if (w_adv) w_next = S_HDR_L;
            S_HDR_L:    if (w_adv) w_next = (r_cnt == '0) ? S_CHK : S_DATA_RD;
            S_DATA_RD:  if (!bus.DATA_empty) w_next = S_DATA_LAT;
            S_DATA_LAT: w_next = S_DATA_TX;
            S_DATA_TX:  if (w_adv) w_next = (r_cnt != '0) ? S_DATA_RD : S_CHK;
            S_CHK:      if (w_adv) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // State, latched INFO/DATA, remaining-byte counter, running checksum and frame counter
    always_ff @(posedge clk_ULPI or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_info      <= '0;
            r_cnt       <= '0;
            r_chk       <= '0;
            r_data      <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_INFO_LAT) begin
                r_info <= bus.INFO_DATA;
                r_cnt  <= CNT_W'(bus.INFO_DATA[INFO_CNT_W-1:0]);
                r_chk  <= bus.INFO_DATA[15:8] ^ bus.INFO_DATA[7:0];
            end
            if (r_state == S_DATA_LAT) begin
                r_data <= bus.DATA_in;
                r_cnt  <= r_cnt - CNT_W'(1);
                r_chk  <= r_chk ^ bus.DATA_in;
            end
            if (r_state == S_CHK && w_adv)
                r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

endmodule
